// File: rtl/ldpc_pkg.sv
// Shared types, default sizing and width helpers for the LDPC encoder sequencer.
package ldpc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_SOLVE,
    ST_OUT
  } state_t;

  localparam int DEF_NUM_Z         = 3;
  localparam int DEF_NUM_INFO_BLKS = 20;
  localparam int DEF_NUM_PAR_BLKS  = 4;
  localparam int DEF_ROM_LAT       = 1;

  // Never return a zero width, even for single-entry ranges.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int rom_addr_w(input int nz, input int ni, input int np);
    return clog2_min1(nz * (ni + np));
  endfunction

  function automatic int z_idx_w(input int nz);
    return clog2_min1(nz);
  endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// One-hot to binary index encoder; valid is high only for exactly one set bit.
module onehot_to_idx #(
  parameter int W  = 3,
  parameter int IW = 2
) (
  input  logic [W-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++)
      if (onehot[i]) idx = idx | IW'(i);
  end

  assign valid = (onehot != '0) && ((onehot & (onehot - W'(1))) == '0);

endmodule

// File: rtl/ldpc_enc_sequencer.sv
// Control sequencer for a QC-LDPC encoder: accumulates info blocks through the
// shift ROM, runs the parity solve steps, then streams the parity blocks out.
module ldpc_enc_sequencer
  import ldpc_pkg::*;
#(
  parameter int NUM_Z         = DEF_NUM_Z,
  parameter int NUM_INFO_BLKS = DEF_NUM_INFO_BLKS,
  parameter int NUM_PAR_BLKS  = DEF_NUM_PAR_BLKS,
  parameter int ROM_LAT       = DEF_ROM_LAT
) (
  input  logic                                                   CLK,
  input  logic                                                   rst_n,
  input  logic                                                   start,
  input  logic [NUM_Z-1:0]                                       req_z,
  input  logic                                                   blk_valid,
  output logic                                                   blk_ready,
  output logic [rom_addr_w(NUM_Z, NUM_INFO_BLKS, NUM_PAR_BLKS)-1:0] rom_addr,
  output logic [z_idx_w(NUM_Z)-1:0]                              z_idx,
  output logic                                                   acc_clr,
  output logic                                                   acc_en,
  output logic                                                   solve_en,
  output logic [clog2_min1(NUM_PAR_BLKS)-1:0]                    solve_step,
  output logic                                                   par_valid,
  input  logic                                                   par_ready,
  output logic [clog2_min1(NUM_PAR_BLKS)-1:0]                    par_idx,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   cfg_err
);

  localparam int AW   = rom_addr_w(NUM_Z, NUM_INFO_BLKS, NUM_PAR_BLKS);
  localparam int ZW   = z_idx_w(NUM_Z);
  localparam int SW   = clog2_min1(NUM_PAR_BLKS);
  localparam int CW   = clog2_min1(NUM_INFO_BLKS);
  localparam int BLKS = NUM_INFO_BLKS + NUM_PAR_BLKS;

  state_t          state;
  logic [CW-1:0]   col;
  logic [ZW-1:0]   z_dec;
  logic            z_ok;
  logic            in_idle;
  logic            accept;
  logic            start_ok;
  logic [ROM_LAT:0] vld_pipe;
  int              addr_i;

  onehot_to_idx #(.W(NUM_Z), .IW(ZW)) u_z_dec (
    .onehot (req_z),
    .idx    (z_dec),
    .valid  (z_ok)
  );

  assign in_idle  = (state == ST_IDLE);
  assign accept   = (state == ST_ACCUM) & blk_valid;
  assign start_ok = in_idle & start & z_ok;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      col        <= '0;
      solve_step <= '0;
      par_idx    <= '0;
      z_idx      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            z_idx      <= z_dec;
            col        <= '0;
            solve_step <= '0;
            par_idx    <= '0;
            state      <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            if (col == CW'(NUM_INFO_BLKS - 1))
              state <= (ROM_LAT == 0) ? ST_SOLVE : ST_DRAIN;
            else
              col <= col + 1'b1;
          end
        end
        // One cycle covers the single legal nonzero ROM latency.
        ST_DRAIN: state <= ST_SOLVE;
        ST_SOLVE: begin
          if (solve_step == SW'(NUM_PAR_BLKS - 1))
            state <= ST_OUT;
          else
            solve_step <= solve_step + 1'b1;
        end
        ST_OUT: begin
          if (par_ready) begin
            if (par_idx == SW'(NUM_PAR_BLKS - 1))
              state <= ST_IDLE;
            else
              par_idx <= par_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // acc_en trails each accept by the ROM read latency.
  generate
    if (ROM_LAT == 0) begin : g_nolat
      assign vld_pipe = accept;
    end else begin : g_lat
      logic [ROM_LAT:1] vld_q;
      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
        end else begin
          vld_q[1] <= accept;
          for (int i = 2; i <= ROM_LAT; i++) vld_q[i] <= vld_q[i-1];
        end
      end
      assign vld_pipe = {vld_q, accept};
    end
  endgenerate

  always_comb begin
    addr_i = int'(z_idx) * BLKS;
    if (state == ST_SOLVE) addr_i = addr_i + NUM_INFO_BLKS + int'(solve_step);
    else                   addr_i = addr_i + int'(col);
    rom_addr = AW'(addr_i);
  end

  // Start-cycle pulses are gated so a held start cannot leak out during reset.
  assign acc_clr   = rst_n & start_ok;
  assign cfg_err   = rst_n & in_idle & start & ~z_ok;
  assign acc_en    = vld_pipe[ROM_LAT];
  assign blk_ready = (state == ST_ACCUM);
  assign solve_en  = (state == ST_SOLVE);
  assign par_valid = (state == ST_OUT);
  assign busy      = ~in_idle;
  assign done      = par_valid & par_ready & (par_idx == SW'(NUM_PAR_BLKS - 1));

endmodule

// File: tb/tb_ldpc_enc_sequencer.sv
// Self-checking bench for ldpc_enc_sequencer: table of codeword starts plus a
// mid-codeword reset sequence, with a negedge monitor scoring every cycle.
module tb_ldpc_enc_sequencer;

  localparam int NI = 20;
  localparam int NP = 4;
  localparam int ROM_LAT = 1;

  logic       CLK = 0;
  logic       rst_n;
  logic       start;
  logic [2:0] req_z;
  logic       blk_valid;
  logic       blk_ready;
  logic [6:0] rom_addr;
  logic [1:0] z_idx;
  logic       acc_clr, acc_en, solve_en;
  logic [1:0] solve_step;
  logic       par_valid, par_ready;
  logic [1:0] par_idx;
  logic       busy, done, cfg_err;

  ldpc_enc_sequencer #(
    .NUM_Z(3), .NUM_INFO_BLKS(NI), .NUM_PAR_BLKS(NP), .ROM_LAT(ROM_LAT)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .req_z(req_z),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .rom_addr(rom_addr),
    .z_idx(z_idx), .acc_clr(acc_clr), .acc_en(acc_en), .solve_en(solve_en),
    .solve_step(solve_step), .par_valid(par_valid), .par_ready(par_ready),
    .par_idx(par_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor state / scoreboard
  bit mon_en = 0;
  int cyc = 0;
  int exp_base = 0;
  int n_clr, n_err, n_acc, n_acc_en, n_solve, n_par, n_done;
  int acc_q[$];
  bit prev_pv, prev_pr, prev_rdy;
  int prev_idx;

  task automatic clr_stats();
    n_clr = 0; n_err = 0; n_acc = 0; n_acc_en = 0;
    n_solve = 0; n_par = 0; n_done = 0;
    acc_q.delete();
    prev_pv = 0; prev_pr = 0; prev_rdy = 0; prev_idx = 0;
  endtask

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (mon_en && rst_n) begin
      chk("mutex", int'($countones({acc_en, solve_en, acc_clr, par_valid}) <= 1), 1);
      if (acc_clr) n_clr++;
      if (cfg_err) n_err++;
      if (prev_pv && !prev_pr) begin
        chk("par_idx_hold", par_idx, prev_idx);
        chk("par_valid_hold", par_valid, 1);
      end
      if (prev_rdy && !blk_ready) chk("drain_after_last", n_acc, NI);
      if (blk_valid && blk_ready) begin
        chk("rom_addr_acc", rom_addr, exp_base + n_acc);
        n_acc++;
        acc_q.push_back(cyc + ROM_LAT);
      end
      if (acc_en) begin
        n_acc_en++;
        chk("acc_en_pending", int'(acc_q.size() > 0), 1);
        if (acc_q.size() > 0) chk("acc_en_lat", cyc, acc_q.pop_front());
      end
      if (solve_en) begin
        chk("solve_step", solve_step, n_solve);
        chk("rom_addr_solve", rom_addr, exp_base + NI + n_solve);
        n_solve++;
      end
      if (par_valid && par_ready) begin
        chk("par_idx_seq", par_idx, n_par);
        n_par++;
      end
      if (done) begin
        chk("done_after_last_par", n_par, NP);
        n_done++;
      end
      prev_pv  = par_valid;
      prev_pr  = par_ready;
      prev_idx = par_idx;
      prev_rdy = blk_ready;
    end
  end

  // Called at posedge+1 with the DUT in IDLE.
  task automatic do_start(input logic [2:0] z, input bit ok, input int zidx);
    start = 1; req_z = z;
    @(negedge CLK);
    chk("acc_clr_on_start", acc_clr, ok);
    chk("cfg_err_on_start", cfg_err, !ok);
    @(posedge CLK); #1;
    start = 0; req_z = 0;
    chk("z_idx_latch", z_idx, zidx);
    chk("busy_after_start", busy, ok);
  endtask

  task automatic run_cw(input bit toggle, input bit stall, input bit inject);
    int stall_cnt;
    int c;
    stall_cnt = 0;
    c = 0;
    while (c < 400 && n_done == 0) begin
      blk_valid = (n_acc < NI) && (!toggle || (c % 2 == 0));
      if (stall && par_valid && par_idx == 2 && stall_cnt < 5) begin
        par_ready = 0;
        stall_cnt++;
      end else begin
        par_ready = 1;
      end
      start = inject && busy;
      req_z = inject ? 3'b111 : 3'b000;
      @(posedge CLK); #1;
      c++;
    end
    start = 0; req_z = 0; blk_valid = 0;
    blk_valid = 0;
    par_ready = 0;
    chk("cw_done_count", n_done, 1);
    chk("cw_acc_clr_count", n_clr, 1);
    chk("cw_accepts", n_acc, NI);
    chk("cw_acc_en_count", n_acc_en, NI);
    chk("cw_acc_q_empty", acc_q.size(), 0);
    chk("cw_solve_count", n_solve, NP);
    chk("cw_par_count", n_par, NP);
    chk("cw_cfg_err_count", n_err, 0);
    chk("cw_idle_after_done", busy, 0);
    if (stall) chk("cw_stall_cycles", stall_cnt, 5);
  endtask

  typedef struct {
    logic [2:0] z;
    bit         ok;
    int         base;
    int         zidx;
    bit         toggle;
    bit         stall;
    bit         inject;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{3'b010, 1, 24, 1, 0, 0, 0};
    vecs[1] = '{3'b110, 0,  0, 1, 0, 0, 0};
    vecs[2] = '{3'b001, 1,  0, 0, 1, 0, 0};
    vecs[3] = '{3'b000, 0,  0, 0, 0, 0, 0};
    vecs[4] = '{3'b100, 1, 48, 2, 0, 1, 1};
    vecs[5] = '{3'b111, 0,  0, 2, 0, 0, 0};

    rst_n = 0; start = 1; req_z = 3'b001; blk_valid = 1; par_ready = 1;
    clr_stats();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ctrl_outs",
        int'({blk_ready, acc_clr, acc_en, solve_en, par_valid, busy, done, cfg_err}), 0);
    chk("reset_counters", int'({z_idx, solve_step, par_idx}), 0);
    chk("reset_rom_addr", rom_addr, 0);
    start = 0; req_z = 0; blk_valid = 0; par_ready = 0;
    #2 rst_n = 1;
    @(posedge CLK); #1;
    mon_en = 1;

    for (int i = 0; i < 6; i++) begin
      clr_stats();
      exp_base = vecs[i].base;
      do_start(vecs[i].z, vecs[i].ok, vecs[i].zidx);
      if (vecs[i].ok) begin
        run_cw(vecs[i].toggle, vecs[i].stall, vecs[i].inject);
      end else begin
        @(negedge CLK);
        chk("err_busy_stays_0", busy, 0);
        chk("err_pulse_count", n_err, 1);
        @(posedge CLK); #1;
      end
    end

    // Reset in the middle of a codeword.
    clr_stats();
    exp_base = 0;
    do_start(3'b001, 1, 0);
    blk_valid = 1;
    for (int c = 0; c < 50 && n_acc < 7; c++) begin
      @(negedge CLK); #1;
    end
    blk_valid = 0;
    chk("mid_accepts", n_acc, 7);
    @(posedge CLK); #1;
    mon_en = 0;
    rst_n = 0;
    #1;
    chk("midrst_ctrl_outs",
        int'({blk_ready, acc_clr, acc_en, solve_en, par_valid, busy, done, cfg_err}), 0);
    chk("midrst_counters", int'({z_idx, solve_step, par_idx}), 0);
    chk("midrst_no_done", n_done, 0);
    #3 rst_n = 1;
    @(posedge CLK); #1;
    clr_stats();
    mon_en = 1;
    exp_base = 48;
    do_start(3'b100, 1, 2);
    run_cw(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ldpc_enc_sequencer.md
LDPC_ENC_SEQUENCER -- requirements
Module: ldpc_enc_sequencer

Interface
REQ-001 SHALL have parameter NUM_Z, default 3, giving the number of supported lifting sizes.
REQ-002 SHALL have parameter NUM_INFO_BLKS, default 20, giving info blocks per codeword.
REQ-003 SHALL have parameter NUM_PAR_BLKS, default 4, giving parity blocks per codeword.
REQ-004 SHALL have parameter ROM_LAT, default 1, giving ROM read latency in cycles (legal values 0 or 1).
REQ-005 SHALL have port CLK, input, 1 bit: clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: codeword start request.
REQ-008 SHALL have port req_z, input, NUM_Z bits: one-hot lifting-size select, sampled when start is accepted.
REQ-009 SHALL have port blk_valid, input, 1 bit: an info block is present.
REQ-010 SHALL have port blk_ready, output, 1 bit: the sequencer accepts an info block.
REQ-011 SHALL have port rom_addr, output, clog2(NUM_Z*(NUM_INFO_BLKS+NUM_PAR_BLKS)) bits: shift-ROM column address.
REQ-012 SHALL have port z_idx, output, clog2(NUM_Z) bits: binary index of the latched lifting size.
REQ-013 SHALL have port acc_clr, output, 1 bit: clears all parity accumulators.
REQ-014 SHALL have port acc_en, output, 1 bit: XOR the shifted block into the accumulators.
REQ-015 SHALL have port solve_en, output, 1 bit: parity-solve step enable.
REQ-016 SHALL have port solve_step, output, clog2(NUM_PAR_BLKS) bits: current solve step.
REQ-017 SHALL have port par_valid, input/output per handshake: output, 1 bit, parity block presented.
REQ-018 SHALL have port par_ready, input, 1 bit: downstream accepts a parity block.
REQ-019 SHALL have port par_idx, output, clog2(NUM_PAR_BLKS) bits: index of the presented parity block.
REQ-020 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-021 SHALL have port done, output, 1 bit: one-cycle pulse when a codeword completes.
REQ-022 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-023 SHALL implement FSM states IDLE, ACCUM, DRAIN, SOLVE and OUT.
REQ-024 In IDLE, start with req_z one-hot SHALL latch z_idx, pulse acc_clr in that cycle, clear col, and go to ACCUM.
REQ-025 In IDLE, start with req_z not one-hot (zero or multi-bit) SHALL pulse cfg_err, leave z_idx unchanged, and remain in IDLE.
REQ-026 start SHALL be ignored outside IDLE, with no error and no state change.
REQ-027 In ACCUM, blk_ready SHALL be 1; an accept is blk_valid & blk_ready.
REQ-028 On each accept, rom_addr SHALL equal z_idx*(NUM_INFO_BLKS+NUM_PAR_BLKS)+col, combinational in the accept cycle, and col SHALL then increment.
REQ-029 acc_en SHALL assert exactly ROM_LAT cycles after each accept, once per accept; gaps in blk_valid produce matching gaps in acc_en.
REQ-030 The accept with col==NUM_INFO_BLKS-1 SHALL move the FSM to DRAIN, with blk_ready=0 from the next cycle.
REQ-031 DRAIN SHALL last ROM_LAT cycles (0 means bypass to SOLVE) so the final acc_en completes before solving.
REQ-032 SOLVE SHALL assert solve_en for NUM_PAR_BLKS consecutive cycles, with solve_step counting 0..NUM_PAR_BLKS-1 and rom_addr set to the parity column (base+NUM_INFO_BLKS+solve_step).
REQ-033 OUT SHALL hold par_valid=1 with par_idx starting at 0, advancing on par_valid & par_ready; par_idx SHALL remain stable while par_ready=0.
REQ-034 Acceptance of par_idx==NUM_PAR_BLKS-1 SHALL pulse done in the same cycle and return the FSM to IDLE; a start in the following cycle SHALL be accepted.
REQ-035 acc_en, solve_en, acc_clr and par_valid SHALL be mutually exclusive in every cycle.
REQ-036 The col and step counters SHALL never wrap; they are cleared on every accepted start.

Reset
REQ-037 On rst_n=0, the FSM SHALL go to IDLE immediately, and col, solve_step, par_idx and z_idx SHALL go to 0.
REQ-038 During reset, blk_ready, acc_clr, acc_en, solve_en, par_valid, busy, done and cfg_err SHALL all be 0.
REQ-039 A reset mid-codeword SHALL abandon the codeword with no done pulse; the first post-reset start SHALL pulse acc_clr.

Structure
REQ-040 The ldpc_pkg package SHALL hold the FSM state enum, default parameter values, and the rom_addr/z_idx width functions.
REQ-041 The one-hot-to-index conversion with validity check SHALL be a sub-module named onehot_to_idx.

Verification
REQ-042 Test 1: req_z=3'b010, start, then 20 back-to-back blocks → acc_clr pulse once, rom_addr 24..43, 20 acc_en pulses each one cycle after its accept, 4 solve_en cycles, par_idx 0..3, done.
REQ-043 Test 2: req_z=3'b110 with start → cfg_err pulse, busy stays 0; a following start with 3'b001 is accepted and rom_addr starts at 0.
REQ-044 Test 3: blk_valid toggling 1-0 → acc_en count is exactly 20, and DRAIN is entered only after the 20th accept.
REQ-045 Test 4: par_ready held 0 for 5 cycles at par_idx=2 → par_idx stays 2 and par_valid stays 1; done occurs only after idx 3 is accepted.
REQ-046 Test 5: rst_n asserted after 7 blocks → all outputs go to 0 immediately; a new start with 3'b100 yields rom_addr 48 and 20 fresh accepts.
REQ-047 Test 6: start asserted during ACCUM and OUT → no effect on state, counters or cfg_err.
